ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: in_valid  input  1  decoded instruction present from ID/EX.
REQ-004 SHALL: in_ready  output  1  instruction accepted this edge when in_valid&in_ready.
REQ-005 SHALL: rtlop_i  input  4  ADD=0 SLL=1 SLT=2 SLTU=3 XOR=4 SHR=5 OR=6 AND=7 SAR=13.
REQ-006 SHALL: rtltype_i  input  2  ARICH=0 RMEM=1 WMEM=2 JUMP=3.
REQ-007 SHALL: pc_i, src1_i, src2_i  input  32 each  operands from decode.
REQ-008 SHALL: gprs_waddr_i  input  5  destination register, 0 = none.
REQ-009 SHALL: ex_gprs_waddr / ex_gprs_wdata  output  5 / 32  combinational forwarding to decode.
REQ-010 SHALL: mem_req, mem_we  output  1 each; mem_addr, mem_wdata  output  32; mem_ack  input  1; mem_rdata  input  32.
REQ-011 SHALL: jump_o  output  1, jump_target_o  output  32  registered redirect to fetch.
REQ-012 SHALL: wb_valid  output  1, wb_waddr  output  5, wb_wdata  output  32  registered writeback to gprs.
REQ-013 SHALL: error_o  output  1  registered illegal-op flag to cpu_ctrl.

Function
REQ-014 SHALL: FSM states IDLE, MEM; in_ready = 1 in IDLE, 0 in MEM.
REQ-015 SHALL: ARICH result: ADD sum mod 2^32; SLL/SHR/SAR shift src1 by src2[4:0]; SLT signed, SLTU unsigned compare (1/0); XOR/OR/AND bitwise.
REQ-016 SHALL: ARICH accepted -> next cycle wb_valid=1, wb_waddr, wb_wdata=result; wb_valid forced 0 when waddr=0.
REQ-017 SHALL: rtlop_i not in REQ-005 set with ARICH -> error_o=1 for one cycle, no writeback.
REQ-018 SHALL: JUMP accepted -> next cycle jump_o=1 one cycle, jump_target_o=(src1_i+src2_i)&~1, writeback pc_i+4 to gprs_waddr_i (REQ-016 rules).
REQ-019 SHALL: in the cycle jump_o=1 any in_valid instruction is accepted and discarded (no writeback, no memory, no jump, no error).
REQ-020 SHALL: RMEM accepted -> latch addr=src1_i+src2_i, we=0, rd; WMEM accepted -> latch addr=src1_i, wdata=src2_i, we=1; enter MEM.
REQ-021 SHALL: in MEM mem_req=1 with stable mem_addr/mem_we/mem_wdata until mem_ack sampled high, then IDLE next cycle.
REQ-022 SHALL: mem_ack in MEM for RMEM -> next cycle wb_valid=1, wb_wdata=mem_rdata; WMEM -> no writeback.
REQ-023 SHALL: mem_ack while IDLE ignored; no wait-cycle limit.
REQ-024 SHALL: mem_req=0 and mem_we=0 in IDLE.
REQ-025 SHALL: forwarding priority: (a) IDLE, in_valid, not discard cycle, ARICH/JUMP, waddr!=0 -> current result; (b) else wb_valid -> wb_waddr/wb_wdata; (c) else waddr=0, wdata=0.
REQ-026 SHALL: wb_valid, jump_o, error_o single-cycle pulses per accepted instruction; latency 1 cycle for ARICH/JUMP, ack+1 for RMEM.

Reset
REQ-027 SHALL: rst_n low -> immediately state IDLE, mem_req=0, mem_we=0, jump_o=0, wb_valid=0, error_o=0, all data/address outputs 0.
REQ-028 SHALL: reset during MEM abandons the access; no writeback after reset release.
REQ-029 SHALL: first instruction acceptable on first rising edge with rst_n high.

Verification
REQ-030 SHALL: ARICH SUB-form ADD src1=5, src2=0xFFFFFFFD, rd=3 -> next cycle wb_valid=1, wb_waddr=3, wb_wdata=2; forwarding shows 3/2 in accept cycle.
REQ-031 SHALL: SAR src1=0x80000000, src2=0x24 -> wb_wdata=0xF8000000; SLT -1 vs 1 -> 1, SLTU -> 0.
REQ-032 SHALL: RMEM src1=0x100, src2=4, rd=7, ack after 3 wait cycles with rdata=0xDEADBEEF -> mem_addr=0x104 held, in_ready=0 throughout, then wb_wdata=0xDEADBEEF, rd=7.
REQ-033 SHALL: JUMP pc=0x40, src1=0x41, src2=0x10, rd=1 -> jump_o=1, target=0x50, wb_wdata=0x44; following in_valid ADD rd=2 discarded.
REQ-034 SHALL: WMEM src1=0x200, src2=0x55 with rst_n dropped mid-wait -> mem_req=0 immediately, no wb_valid after release.
REQ-035 SHALL: rtlop=9 ARICH rd=4 -> error_o=1 one cycle, wb_valid=0.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage -- ALU, jump redirect, single-outstanding memory access, writeback and forwarding
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  rtlop_i,
  input  logic [1:0]  rtltype_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic [4:0]  gprs_waddr_i,
  output logic [4:0]  ex_gprs_waddr,
  output logic [31:0] ex_gprs_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        jump_o,
  output logic [31:0] jump_target_o,
  output logic        wb_valid,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        error_o
);
  typedef enum logic {IDLE, MEM} state_t;
  state_t r_state, w_next;
  logic        r_we;
  logic [4:0]  r_rd;
  logic [31:0] w_alu, w_result;
  logic        w_legal, w_take, w_arith, w_rmem, w_wmem, w_jump, w_wr, w_fwd, w_ack, w_mem_wb;
  assign in_ready = r_state == IDLE;
  // an instruction arriving while jump_o is high is on the wrong path: accepted but dropped
  assign w_take   = in_valid & in_ready & ~jump_o;
  assign w_arith  = rtltype_i == 2'd0;
  assign w_rmem   = rtltype_i == 2'd1;
  assign w_wmem   = rtltype_i == 2'd2;
  assign w_jump   = rtltype_i == 2'd3;
  assign w_ack    = (r_state == MEM) & mem_ack;
  assign w_mem_wb = w_ack & ~r_we & (r_rd != 5'd0);
  assign mem_req  = r_state == MEM;
  assign mem_we   = mem_req & r_we;
  always_comb begin
    w_alu   = '0;
    w_legal = 1'b1;
    case (rtlop_i)
      4'd0:    w_alu = src1_i + src2_i;
      4'd1:    w_alu = src1_i << src2_i[4:0];
      4'd2:    w_alu = {31'd0, $signed(src1_i) < $signed(src2_i)};
      4'd3:    w_alu = {31'd0, src1_i < src2_i};
      4'd4:    w_alu = src1_i ^ src2_i;
      4'd5:    w_alu = src1_i >> src2_i[4:0];
      4'd6:    w_alu = src1_i | src2_i;
      4'd7:    w_alu = src1_i & src2_i;
      4'd13:   w_alu = 32'($signed(src1_i) >>> src2_i[4:0]);
      default: w_legal = 1'b0;
    endcase
  end
  assign w_result = w_jump ? pc_i + 32'd4 : w_alu;
  assign w_fwd    = w_take & (w_arith | w_jump) & (gprs_waddr_i != 5'd0);
  assign w_wr     = w_fwd & (w_jump | w_legal);
  assign ex_gprs_waddr = w_fwd ? gprs_waddr_i : wb_valid ? wb_waddr : 5'd0;
  assign ex_gprs_wdata = w_fwd ? w_result : wb_valid ? wb_wdata : 32'd0;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_take && (w_rmem || w_wmem)) w_next = MEM;
    if (w_ack) w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_waddr      <= '0;
      wb_wdata      <= '0;
      jump_o        <= 1'b0;
      jump_target_o <= '0;
      error_o       <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      r_we          <= 1'b0;
      r_rd          <= '0;
    end else begin
      wb_valid <= w_wr | w_mem_wb;
      jump_o   <= w_take & w_jump;
      error_o  <= w_take & w_arith & ~w_legal;
      if (w_wr) begin
        wb_waddr <= gprs_waddr_i;
        wb_wdata <= w_result;
      end else if (w_mem_wb) begin
        wb_waddr <= r_rd;
        wb_wdata <= mem_rdata;
      end
      if (w_take & w_jump) jump_target_o <= (src1_i + src2_i) & ~32'd1;
      if (w_take & (w_rmem | w_wmem)) begin
        mem_addr  <= w_rmem ? src1_i + src2_i : src1_i;
        mem_wdata <= w_rmem ? 32'd0 : src2_i;
        r_we      <= w_wmem;
        r_rd      <= gprs_waddr_i;
      end
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for ex_stage
module tb_ex_stage;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready;
  logic [3:0]  rtlop_i = '0;
  logic [1:0]  rtltype_i = '0;
  logic [31:0] pc_i = '0, src1_i = '0, src2_i = '0;
  logic [4:0]  gprs_waddr_i = '0, ex_gprs_waddr, wb_waddr;
  logic [31:0] ex_gprs_wdata, mem_addr, mem_wdata, jump_target_o, wb_wdata;
  logic        mem_req, mem_we, jump_o, wb_valid, error_o;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  int checks = 0, failures = 0;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rtlop_i(rtlop_i), .rtltype_i(rtltype_i), .pc_i(pc_i), .src1_i(src1_i), .src2_i(src2_i),
    .gprs_waddr_i(gprs_waddr_i), .ex_gprs_waddr(ex_gprs_waddr), .ex_gprs_wdata(ex_gprs_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .jump_o(jump_o), .jump_target_o(jump_target_o),
    .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] t, input logic [3:0] op, input logic [31:0] pc, s1, s2, input logic [4:0] rd);
    in_valid = 1'b1; rtltype_i = t; rtlop_i = op; pc_i = pc; src1_i = s1; src2_i = s2; gprs_waddr_i = rd;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({mem_req, mem_we, jump_o, wb_valid, error_o} !== 5'b0) begin failures++; $display("FAIL reset_flags got %b exp 00000", {mem_req, mem_we, jump_o, wb_valid, error_o}); end
    checks++; if ({mem_addr, mem_wdata, wb_wdata, jump_target_o} !== 128'd0) begin failures++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, wb_wdata, jump_target_o}); end
    checks++; if ({ex_gprs_waddr, wb_waddr, ex_gprs_wdata} !== 42'd0) begin failures++; $display("FAIL reset_fwd got %h exp 0", {ex_gprs_waddr, wb_waddr, ex_gprs_wdata}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_add();
    drive(2'd0, 4'd0, 32'h0, 32'd5, 32'hFFFF_FFFD, 5'd3);
    #1;
    checks++; if ({ex_gprs_waddr, ex_gprs_wdata} !== {5'd3, 32'd2}) begin failures++; $display("FAIL add_fwd got %0d/%h exp 3/2", ex_gprs_waddr, ex_gprs_wdata); end
    step();
    checks++; if ({wb_valid, wb_waddr, wb_wdata} !== {1'b1, 5'd3, 32'd2}) begin failures++; $display("FAIL add_wb got %b/%0d/%h exp 1/3/2", wb_valid, wb_waddr, wb_wdata); end
    in_valid = 1'b0; #1;
    checks++; if ({ex_gprs_waddr, ex_gprs_wdata} !== {5'd3, 32'd2}) begin failures++; $display("FAIL add_fwd_wb got %0d/%h exp 3/2", ex_gprs_waddr, ex_gprs_wdata); end
    step();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL add_pulse got %b exp 0", wb_valid); end
    checks++; if ({ex_gprs_waddr, ex_gprs_wdata} !== 37'd0) begin failures++; $display("FAIL fwd_none got %0d/%h exp 0/0", ex_gprs_waddr, ex_gprs_wdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops [8] = '{4'd13, 4'd2, 4'd3, 4'd1, 4'd5, 4'd4, 4'd6, 4'd7};
    logic [31:0] a   [8] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h8000_0000, 32'hF0F0_F0F0, 32'h0F, 32'h0F};
    logic [31:0] b   [8] = '{32'h24, 32'h1, 32'h1, 32'h21, 32'h1F, 32'hFF00_FF00, 32'hF0, 32'h3C};
    logic [31:0] exp [8] = '{32'hF800_0000, 32'h1, 32'h0, 32'h2, 32'h1, 32'h0FF0_0FF0, 32'hFF, 32'h0C};
    for (int i = 0; i < 8; i++) begin
      drive(2'd0, ops[i], 32'h0, a[i], b[i], 5'(10 + i));
      #1;
      checks++; if (ex_gprs_wdata !== exp[i]) begin failures++; $display("FAIL alu_fwd[%0d] got %h exp %h", i, ex_gprs_wdata, exp[i]); end
      step();
      checks++; if ({wb_valid, wb_waddr, wb_wdata} !== {1'b1, 5'(10 + i), exp[i]}) begin failures++; $display("FAIL alu_wb[%0d] got %b/%0d/%h exp 1/%0d/%h", i, wb_valid, wb_waddr, wb_wdata, 10 + i, exp[i]); end
      @(negedge clk);
    end
    drive(2'd0, 4'd0, 32'h0, 32'd1, 32'd1, 5'd0);
    step();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL rd0_wb got %b exp 0", wb_valid); end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rmem();
    drive(2'd1, 4'd0, 32'h0, 32'h100, 32'h4, 5'd7);
    step();
    in_valid = 1'b0;
    checks++; if ({mem_req, mem_we, in_ready, mem_addr} !== {3'b100, 32'h104}) begin failures++; $display("FAIL rmem_issue got %b%b%b/%h exp 100/104", mem_req, mem_we, in_ready, mem_addr); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({mem_req, in_ready, wb_valid, mem_addr} !== {3'b100, 32'h104}) begin failures++; $display("FAIL rmem_wait[%0d] got %b%b%b/%h exp 100/104", i, mem_req, in_ready, wb_valid, mem_addr); end
    end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h1234_5678;
    checks++; if ({wb_valid, wb_waddr, wb_wdata} !== {1'b1, 5'd7, 32'hDEAD_BEEF}) begin failures++; $display("FAIL rmem_wb got %b/%0d/%h exp 1/7/deadbeef", wb_valid, wb_waddr, wb_wdata); end
    checks++; if ({mem_req, in_ready} !== 2'b01) begin failures++; $display("FAIL rmem_done got %b%b exp 01", mem_req, in_ready); end
    @(negedge clk); mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++; if ({wb_valid, mem_req} !== 2'b00) begin failures++; $display("FAIL idle_ack got %b%b exp 00", wb_valid, mem_req); end
    @(negedge clk);
  endtask

  task automatic test_jump();
    drive(2'd3, 4'd0, 32'h40, 32'h41, 32'h10, 5'd1);
    step();
    checks++; if ({jump_o, jump_target_o} !== {1'b1, 32'h50}) begin failures++; $display("FAIL jump got %b/%h exp 1/50", jump_o, jump_target_o); end
    checks++; if ({wb_valid, wb_waddr, wb_wdata} !== {1'b1, 5'd1, 32'h44}) begin failures++; $display("FAIL jump_wb got %b/%0d/%h exp 1/1/44", wb_valid, wb_waddr, wb_wdata); end
    drive(2'd0, 4'd0, 32'h0, 32'd1, 32'd1, 5'd2);
    #1;
    checks++; if ({in_ready, ex_gprs_waddr, ex_gprs_wdata} !== {1'b1, 5'd1, 32'h44}) begin failures++; $display("FAIL discard_fwd got %b/%0d/%h exp 1/1/44", in_ready, ex_gprs_waddr, ex_gprs_wdata); end
    step();
    in_valid = 1'b0;
    checks++; if ({jump_o, wb_valid, error_o, mem_req} !== 4'b0) begin failures++; $display("FAIL discard got %b%b%b%b exp 0000", jump_o, wb_valid, error_o, mem_req); end
    @(negedge clk);
  endtask

  task automatic test_wmem();
    drive(2'd2, 4'd0, 32'h0, 32'h300, 32'h77, 5'd6);
    step();
    in_valid = 1'b0;
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h300, 32'h77}) begin failures++; $display("FAIL wmem_issue got %b%b/%h/%h exp 11/300/77", mem_req, mem_we, mem_addr, mem_wdata); end
    @(negedge clk); mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    checks++; if ({mem_req, mem_we, wb_valid} !== 3'b000) begin failures++; $display("FAIL wmem_done got %b%b%b exp 000", mem_req, mem_we, wb_valid); end
    @(negedge clk);
    drive(2'd2, 4'd0, 32'h0, 32'h200, 32'h55, 5'd5);
    step();
    in_valid = 1'b0;
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h200, 32'h55}) begin failures++; $display("FAIL wmem2_issue got %b%b/%h/%h exp 11/200/55", mem_req, mem_we, mem_addr, mem_wdata); end
    @(negedge clk); #2 rst_n = 1'b0; #1;
    checks++; if ({mem_req, mem_we, in_ready, mem_addr} !== {3'b001, 32'h0}) begin failures++; $display("FAIL wmem_rst got %b%b%b/%h exp 001/0", mem_req, mem_we, in_ready, mem_addr); end
    @(negedge clk); rst_n = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({wb_valid, mem_req} !== 2'b00) begin failures++; $display("FAIL post_rst[%0d] got %b%b exp 00", i, wb_valid, mem_req); end
    end
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_error();
    drive(2'd0, 4'd9, 32'h0, 32'd3, 32'd4, 5'd4);
    step();
    in_valid = 1'b0;
    checks++; if ({error_o, wb_valid} !== 2'b10) begin failures++; $display("FAIL error got %b%b exp 10", error_o, wb_valid); end
    step();
    checks++; if ({error_o, wb_valid} !== 2'b00) begin failures++; $display("FAIL error_pulse got %b%b exp 00", error_o, wb_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_rmem();
    test_jump();
    test_wmem();
    test_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
